// File: rtl/contador_regressivo_bcd_pkg.sv
// Shared types and constants for the BCD countdown timer (contador_regressivo_bcd).
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned BCD_W        = 4;
  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
  localparam logic [3:0]  DIGIT_MAX    = 4'd9;

  // Clamp an out-of-range digit to the largest legal value for its position.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d,
                                               input logic [BCD_W-1:0] max_val);
    return (d > max_val) ? max_val : d;
  endfunction

endpackage

// File: rtl/contador_regressivo_bcd_digit.sv
// One BCD digit that counts down, reloading max_val and borrowing when it passes through 0.
module bcd_digit_down
  import contador_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             dec,
  input  logic             load,
  input  logic [BCD_W-1:0] max_val,
  input  logic [BCD_W-1:0] d_in,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out
);

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d_in;
    end else if (dec) begin
      r_q <= (r_q == '0) ? max_val : (r_q - 4'd1);
    end
  end

  assign q          = r_q;
  assign borrow_out = dec & (r_q == '0);

endmodule

// File: rtl/contador_regressivo_bcd.sv
// Non-recycling mm:ss BCD countdown timer; stops at 00:00 and reports completion.
// Macro CONTADOR_DONE_HOLD_EN: done held high throughout DONE instead of a 1-cycle pulse.
module contador_regressivo_bcd
  import contador_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] min_q,
  output logic [7:0] sec_q,
  output logic       running,
  output logic       zero,
  output logic       done
);

  localparam int unsigned    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRESC_ONE = PW'(1);

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic            r_running, r_done;
  logic            w_load_en, w_dec, w_done_nxt;
  logic            w_tick, w_last, w_zero;
  logic [3:0]      w_su, w_st, w_mu, w_mt;
  logic            w_borrow_su, w_borrow_st, w_borrow_mu, w_borrow_mt;
  logic [7:0]      w_min, w_sec;

  assign w_min  = {w_mt, w_mu};
  assign w_sec  = {w_st, w_su};
  assign w_zero = (w_min == '0) && (w_sec == '0);
  assign w_last = (w_min == '0) && (w_sec == 8'h01);
  assign w_tick = (r_presc == TICK_LAST);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_running <= (w_state_nxt == RUN);
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_load_en   = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      RUN: begin
        if (stop) begin
          w_state_nxt = PAUSE;
        end else begin
          w_presc_nxt = w_tick ? '0 : (r_presc + PRESC_ONE);
          if (w_tick) begin
            w_dec = 1'b1;
            if (w_last) w_state_nxt = DONE;
          end
        end
      end
      default: begin
        if (load) begin
          w_load_en   = 1'b1;
          w_state_nxt = IDLE;
        end else if (start && !stop && !w_zero && (r_state != DONE)) begin
          w_state_nxt = RUN;
          w_presc_nxt = '0;
        end
      end
    endcase
`ifdef CONTADOR_DONE_HOLD_EN
    w_done_nxt = (w_state_nxt == DONE);
`else
    w_done_nxt = (w_state_nxt == DONE) && (r_state != DONE);
`endif
  end

  bcd_digit_down u_sec_units (
    .clock(clock), .clear(clear), .dec(w_dec), .load(w_load_en),
    .max_val(DIGIT_MAX), .d_in(bcd_sat(sec_in[3:0], DIGIT_MAX)),
    .q(w_su), .borrow_out(w_borrow_su)
  );

  bcd_digit_down u_sec_tens (
    .clock(clock), .clear(clear), .dec(w_borrow_su), .load(w_load_en),
    .max_val(SEC_TENS_MAX), .d_in(bcd_sat(sec_in[7:4], SEC_TENS_MAX)),
    .q(w_st), .borrow_out(w_borrow_st)
  );

  bcd_digit_down u_min_units (
    .clock(clock), .clear(clear), .dec(w_borrow_st), .load(w_load_en),
    .max_val(DIGIT_MAX), .d_in(bcd_sat(min_in[3:0], DIGIT_MAX)),
    .q(w_mu), .borrow_out(w_borrow_mu)
  );

  bcd_digit_down u_min_tens (
    .clock(clock), .clear(clear), .dec(w_borrow_mu), .load(w_load_en),
    .max_val(DIGIT_MAX), .d_in(bcd_sat(min_in[7:4], DIGIT_MAX)),
    .q(w_mt), .borrow_out(w_borrow_mt)
  );

  // Decrement is only issued on a nonzero value, so the top digit can never borrow.
  a_no_underflow: assert property (@(posedge clock) disable iff (clear) !w_borrow_mt);

  assign min_q   = w_min;
  assign sec_q   = w_sec;
  assign running = r_running;
  assign done    = r_done;
  assign zero    = w_zero;

endmodule

// File: tb/tb_contador_regressivo_bcd.sv
// Directed table-driven bench for contador_regressivo_bcd with TICK_DIV=2.
module tb_contador_regressivo_bcd;

`ifdef CONTADOR_DONE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       clear, load, start, stop;
  logic [7:0] min_in, sec_in;
  logic [7:0] min_q, sec_q;
  logic       running, zero, done;

  contador_regressivo_bcd #(.TICK_DIV(2)) dut (
    .clock(clock), .clear(clear), .load(load), .min_in(min_in), .sec_in(sec_in),
    .start(start), .stop(stop), .min_q(min_q), .sec_q(sec_q),
    .running(running), .zero(zero), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       clr, ld, st, sp;
    logic [7:0] mi, si, em, es;
    logic       er, ez, ed;
  } vec_t;

  vec_t tbl[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic add(input logic clr, ld, st, sp, input logic [7:0] mi, si, em, es,
                     input logic er, ez, ed);
    tbl.push_back('{clr, ld, st, sp, mi, si, em, es, er, ez, ed});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    int high;
    vec_t v;
    clear = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    min_in = '0; sec_in = '0;

    //   clr ld st sp  min    sec    exp_min exp_sec run zero done
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    add(0, 1, 0, 0, 8'h00, 8'h03, 8'h00, 8'h03, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h03, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h03, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    for (int i = 0; i < 10; i++)
      add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, HOLD);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, HOLD);
    add(0, 1, 0, 0, 8'h10, 8'h00, 8'h10, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h10, 8'h00, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h10, 8'h00, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h09, 8'h59, 1, 0, 0);
    add(0, 0, 0, 1, 8'h00, 8'h00, 8'h09, 8'h59, 0, 0, 0);
    add(0, 1, 0, 0, 8'h01, 8'h00, 8'h01, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 8'h00, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h00, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h59, 1, 0, 0);
    add(0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h59, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h59, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h59, 1, 0, 0);
    add(0, 1, 0, 0, 8'h12, 8'h34, 8'h00, 8'h59, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h58, 1, 0, 0);
    add(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h58, 0, 0, 0);
    add(0, 1, 0, 0, 8'hA3, 8'h7A, 8'h93, 8'h59, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    add(0, 1, 1, 0, 8'h00, 8'h05, 8'h00, 8'h05, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h42, 8'h00, 8'h42, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h42, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h42, 1, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      clear = v.clr; load = v.ld; start = v.st; stop = v.sp;
      min_in = v.mi; sec_in = v.si;
      step();
      tests++;
      if ({min_q, sec_q, running, zero, done} !== {v.em, v.es, v.er, v.ez, v.ed}) begin
        failed++;
        $display("FAIL row%0d: got %h:%h run=%b zero=%b done=%b, expected %h:%h run=%b zero=%b done=%b",
                 i, min_q, sec_q, running, zero, done, v.em, v.es, v.er, v.ez, v.ed);
      end
    end
    clear = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;

    // done width: run 00:01 to completion and count cycles with done high.
    load = 1'b1; min_in = 8'h00; sec_in = 8'h01; step();
    load = 1'b0; start = 1'b1; step();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      failed++;
      $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, n);
    end
    high = 1;
    repeat (6) begin
      step();
      if (done === 1'b1) high++;
    end
    tests++;
    if (high != (HOLD ? 7 : 1)) begin
      failed++;
      $display("FAIL done_width: high for %0d cycles, expected %0d", high, HOLD ? 7 : 1);
    end
    tests++;
    if ({min_q, sec_q, zero, running} !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL done_hold_value: got %h:%h zero=%b run=%b, expected 00:00 zero=1 run=0",
               min_q, sec_q, zero, running);
    end

    load = 1'b1; min_in = 8'h00; sec_in = 8'h07; step();
    load = 1'b0;
    tests++;
    if ({done, min_q, sec_q} !== {1'b0, 8'h00, 8'h07}) begin
      failed++;
      $display("FAIL load_clears_done: got done=%b %h:%h, expected done=0 00:07", done, min_q, sec_q);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
